// File: rtl/conv_mac_pipe.sv
// ---------------------------------------------------------------------------
// conv_mac_pipe
//
// Three-stage convolution multiply-accumulate pipeline. A window of TAPS
// unsigned N-bit pixels is multiplied tap-by-tap with a stored kernel of TAPS
// unsigned N-bit coefficients. The products are summed and the sum is scaled
// by a right shift of SHIFT bits.
//
//   S1 : registers the TAPS products (2N bits each)
//   S2 : registers the sum (2N+4 bits, wide enough for 16 full-scale taps)
//   S3 : registers the scaled N-bit result (drives out_data / out_valid)
//
// Each stage accepts new data only when the stage after it is empty or is
// handing its data on. This allows one window per cycle while out_ready is
// high, and stalls cleanly under backpressure.
//
// Build option:
//   CONV_MAC_SATURATE_EN  when defined, a scaled result above 2^N-1 clamps to
//                         2^N-1. When undefined, the low N bits of the scaled
//                         sum are kept (plain truncation).
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   k_we       kernel write strobe (kernel register loads k_data)
//   k_data     coefficients, tap i at [(i+1)*N-1 : i*N]
//   in_valid   window valid
//   in_ready   block can accept a window (does not depend on in_valid)
//   in_data    pixel window, same tap packing as k_data
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   out_data   scaled MAC result
//   busy       some pipeline stage holds valid data
// ---------------------------------------------------------------------------
module conv_mac_pipe #(
    parameter int N     = 8,
    parameter int TAPS  = 9,
    parameter int SHIFT = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              k_we,
    input  logic [N*TAPS-1:0] k_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N*TAPS-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N-1:0]      out_data,
    output logic              busy
);
    localparam int PW = 2 * N;      // product width
    localparam int SW = 2 * N + 4;  // sum width

    logic [N*TAPS-1:0]       kernel_q;
    logic [TAPS-1:0][PW-1:0] prod_d;
    logic [TAPS-1:0][PW-1:0] prod_q;
    logic [SW-1:0]           sum_d;
    logic [SW-1:0]           sum_q;
    logic [N-1:0]            res_d;
    logic [N-1:0]            res_q;
    logic                    s1_valid_q;
    logic                    s2_valid_q;
    logic                    s3_valid_q;
    logic                    s1_ready;
    logic                    s2_ready;
    logic                    s3_ready;

    // A stage can take new data when it is empty or its content moves on
    // during this same edge.
    assign s3_ready = !s3_valid_q || out_ready;
    assign s2_ready = !s2_valid_q || s3_ready;
    assign s1_ready = !s1_valid_q || s2_ready;
    assign in_ready = s1_ready;

    // S1 products. The registered kernel is used, so a kernel write on the
    // same edge as an acceptance only affects later windows.
    genvar gi;
    generate
        for (gi = 0; gi < TAPS; gi++) begin : g_tap
            logic [PW-1:0] pix_ext;
            logic [PW-1:0] coef_ext;
            assign pix_ext    = {{N{1'b0}}, in_data[gi*N +: N]};
            assign coef_ext   = {{N{1'b0}}, kernel_q[gi*N +: N]};
            assign prod_d[gi] = pix_ext * coef_ext;
        end
    endgenerate

    // S2 sum of all products.
    always_comb begin
        sum_d = '0;
        for (int i = 0; i < TAPS; i++) begin
            sum_d = sum_d + SW'(prod_q[i]);
        end
    end

    // S3 scaling.
`ifdef CONV_MAC_SATURATE_EN
    logic [SW-1:0] scaled;
    assign scaled = sum_q >> SHIFT;
    assign res_d  = (|scaled[SW-1:N]) ? {N{1'b1}} : scaled[N-1:0];
`else
    assign res_d = sum_q[SHIFT +: N];
`endif

    // Fraction bits below SHIFT are discarded on purpose.
    // When truncating, the overflow bits are discarded as well.
    logic unused_sum;
    assign unused_sum = ^sum_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kernel_q   <= '0;
            prod_q     <= '0;
            sum_q      <= '0;
            res_q      <= '0;
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s3_valid_q <= 1'b0;
        end else begin
            if (k_we) begin
                kernel_q <= k_data;
            end
            if (s1_ready) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    prod_q <= prod_d;
                end
            end
            if (s2_ready) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    sum_q <= sum_d;
                end
            end
            if (s3_ready) begin
                s3_valid_q <= s2_valid_q;
                if (s2_valid_q) begin
                    res_q <= res_d;
                end
            end
        end
    end

    assign out_valid = s3_valid_q;
    assign out_data  = res_q;
    assign busy      = s1_valid_q || s2_valid_q || s3_valid_q;

endmodule

// File: tb/tb_conv_mac_pipe.sv
// ---------------------------------------------------------------------------
// tb_conv_mac_pipe
//
// Self-checking bench for conv_mac_pipe (N=8, TAPS=9, SHIFT=7).
//
// Stimulus is applied one cycle at a time through tick(). tick() looks at
// the handshakes just before each edge:
//   - every accepted window pushes its expected result, computed from the
//     kernel the model holds at that moment, onto exp_q;
//   - every consumed result is pushed onto got_q.
// Each test task then compares these queues and the live outputs inline.
// ---------------------------------------------------------------------------
module tb_conv_mac_pipe;
    localparam int N     = 8;
    localparam int TAPS  = 9;
    localparam int SHIFT = 7;
    localparam int W     = N * TAPS;
`ifdef CONV_MAC_SATURATE_EN
    localparam int SAT_EXP = 255;
`else
    localparam int SAT_EXP = 220;  // (585225 >> 7) = 4572, low byte 0xDC
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         k_we;
    logic [W-1:0] k_data;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_data;
    logic         busy;

    always #5 clk = ~clk;

    conv_mac_pipe #(.N(N), .TAPS(TAPS), .SHIFT(SHIFT)) dut (
        .clk(clk), .rst(rst), .k_we(k_we), .k_data(k_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy)
    );

    int           vectors     = 0;
    int           miscompares = 0;
    logic [W-1:0] kmodel;
    int           exp_q[$];
    int           got_q[$];
    int           got_cyc[$];
    int           cyc         = 0;
    bit           last_acc;

    // Reference: dot product, shift, then clamp or keep the low N bits.
    function automatic int ref_out(input logic [W-1:0] k, input logic [W-1:0] w);
        longint sum = 0;
        longint sc;
        for (int i = 0; i < TAPS; i++) begin
            sum += longint'(k[i*N +: N]) * longint'(w[i*N +: N]);
        end
        sc = sum / (longint'(1) << SHIFT);
`ifdef CONV_MAC_SATURATE_EN
        if (sc > (longint'(1) << N) - 1) sc = (longint'(1) << N) - 1;
`endif
        return int'(sc % (longint'(1) << N));
    endfunction

    function automatic logic [W-1:0] fill(input int v);
        logic [W-1:0] r;
        for (int i = 0; i < TAPS; i++) r[i*N +: N] = N'(v);
        return r;
    endfunction

    function automatic logic [W-1:0] rand_vec();
        logic [W-1:0] r;
        logic [31:0]  x;
        for (int i = 0; i < TAPS; i++) begin
            x = $urandom;
            r[i*N +: N] = x[N-1:0];
        end
        return r;
    endfunction

    task automatic clear_sb();
        exp_q.delete();
        got_q.delete();
        got_cyc.delete();
    endtask

    // One clock cycle. Handshakes are recorded before the edge, and the
    // task returns 1 ns after the edge.
    task automatic tick();
        bit acc;
        bit take;
        #1;
        acc  = (in_valid === 1'b1) && (in_ready === 1'b1) && (rst === 1'b0);
        take = (out_valid === 1'b1) && (out_ready === 1'b1);
        if (acc) exp_q.push_back(ref_out(kmodel, in_data));
        if (take) begin
            got_q.push_back(int'(out_data));
            got_cyc.push_back(cyc);
        end
        if (k_we && !rst) kmodel = k_data;
        last_acc = acc;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain(output bit ok);
        in_valid  = 1'b0;
        k_we      = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && busy; i++) tick();
        ok = (busy === 1'b0);
    endtask

    task automatic test_reset();
        bit ok;
        rst = 1'b1; k_we = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_data = '0; k_data = '0;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b expected 0", busy); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
        vectors++; if (out_data !== '0) begin miscompares++; $display("FAIL rst_out_data: got %0d expected 0", out_data); end
        // A kernel write while reset is held must not take effect.
        k_we = 1'b1; k_data = fill(9);
        @(posedge clk);
        #1;
        k_we = 1'b0; rst = 1'b0; kmodel = '0; clear_sb();
        in_valid = 1'b1; in_data = rand_vec();
        tick();
        in_valid = 1'b0;
        vectors++; if (last_acc !== 1'b1) begin miscompares++; $display("FAIL rst_first_accept: got %b expected 1", last_acc); end
        drain(ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL rst_drain_timeout: busy %b expected 0", busy); end
        vectors++;
        if (got_q.size() != 1) begin miscompares++; $display("FAIL rst_zero_kernel_count: got %0d expected 1", got_q.size()); end
        else if (got_q[0] != 0) begin miscompares++; $display("FAIL rst_zero_kernel: got %0d expected 0", got_q[0]); end
        $display("test_reset done");
    endtask

    task automatic test_basic_mac();
        bit ok;
        int edges;
        clear_sb(); out_ready = 1'b1;
        k_we = 1'b1; k_data = fill(14); in_valid = 1'b0;
        tick();
        k_we = 1'b0; in_valid = 1'b1; in_data = fill(100);
        tick();
        in_valid = 1'b0;
        vectors++; if (last_acc !== 1'b1) begin miscompares++; $display("FAIL basic_accept: got %b expected 1", last_acc); end
        // The acceptance edge is edge 1, and out_valid should rise at edge 3.
        edges = 1;
        for (int i = 0; i < 6 && out_valid !== 1'b1; i++) begin
            tick();
            edges++;
        end
        vectors++; if (edges != 3) begin miscompares++; $display("FAIL basic_latency: got %0d edges expected 3", edges); end
        vectors++; if (out_data !== 8'd98) begin miscompares++; $display("FAIL basic_value: got %0d expected 98", out_data); end
        vectors++; if (int'(out_data) != exp_q[0]) begin miscompares++; $display("FAIL basic_model: got %0d expected %0d", out_data, exp_q[0]); end
        drain(ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL basic_drain_timeout: busy %b expected 0", busy); end
        $display("test_basic_mac done: out_data=%0d edges=%0d", got_q.size() > 0 ? got_q[0] : -1, edges);
    endtask

    task automatic test_streaming();
        bit ok;
        clear_sb(); out_ready = 1'b1;
        k_we = 1'b1; k_data = rand_vec(); in_valid = 1'b0;
        tick();
        k_we = 1'b0;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1; in_data = rand_vec();
            tick();
            vectors++; if (last_acc !== 1'b1) begin miscompares++; $display("FAIL stream_in_ready[%0d]: got %b expected 1", i, in_ready); end
        end
        drain(ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL stream_drain_timeout: busy %b expected 0", busy); end
        vectors++; if (got_q.size() != 20) begin miscompares++; $display("FAIL stream_count: got %0d expected 20", got_q.size()); end
        else begin
            vectors++; if (got_cyc[19] - got_cyc[0] != 19) begin miscompares++; $display("FAIL stream_consecutive: span %0d expected 19", got_cyc[19] - got_cyc[0]); end
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            vectors++; if (got_q[i] != exp_q[i]) begin miscompares++; $display("FAIL stream_data[%0d]: got %0d expected %0d", i, got_q[i], exp_q[i]); end
        end
        $display("test_streaming done: %0d results", got_q.size());
    endtask

    task automatic test_backpressure();
        bit           ok;
        int           accepted;
        logic [N-1:0] held;
        clear_sb(); accepted = 0; held = '0;
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = rand_vec();
            tick();
            accepted += int'(last_acc);
            if (i == 2) held = out_data;
            if (i >= 2) begin
                vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_out_valid[%0d]: got %b expected 1", i, out_valid); end
            end
            if (i > 2) begin
                vectors++; if (out_data !== held) begin miscompares++; $display("FAIL bp_hold[%0d]: got %0d expected %0d", i, out_data, held); end
            end
        end
        vectors++; if (accepted != 3) begin miscompares++; $display("FAIL bp_accepted: got %0d expected 3", accepted); end
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready: got %b expected 0", in_ready); end
        drain(ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL bp_drain_timeout: busy %b expected 0", busy); end
        vectors++; if (got_q.size() != 3) begin miscompares++; $display("FAIL bp_count: got %0d expected 3", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            vectors++; if (got_q[i] != exp_q[i]) begin miscompares++; $display("FAIL bp_data[%0d]: got %0d expected %0d", i, got_q[i], exp_q[i]); end
        end
        $display("test_backpressure done: accepted=%0d results=%0d", accepted, got_q.size());
    endtask

    task automatic test_kernel_swap();
        bit ok;
        clear_sb(); out_ready = 1'b1;
        k_we = 1'b1; k_data = fill(14); in_valid = 1'b0;
        tick();
        // The kernel write and W1 happen on the same edge.
        k_data = fill(2); in_valid = 1'b1; in_data = fill(255);
        tick();
        k_we = 1'b0; in_data = fill(255);
        tick();
        drain(ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL swap_drain_timeout: busy %b expected 0", busy); end
        vectors++;
        if (got_q.size() != 2) begin miscompares++; $display("FAIL swap_count: got %0d expected 2", got_q.size()); end
        else begin
            vectors++; if (got_q[0] != 251) begin miscompares++; $display("FAIL swap_w1: got %0d expected 251", got_q[0]); end
            vectors++; if (got_q[1] != 35) begin miscompares++; $display("FAIL swap_w2: got %0d expected 35", got_q[1]); end
            vectors++; if (got_q[0] != exp_q[0] || got_q[1] != exp_q[1]) begin miscompares++; $display("FAIL swap_model: got %0d,%0d expected %0d,%0d", got_q[0], got_q[1], exp_q[0], exp_q[1]); end
        end
        $display("test_kernel_swap done");
    endtask

    task automatic test_saturation();
        bit ok;
        clear_sb(); out_ready = 1'b1;
        k_we = 1'b1; k_data = fill(255); in_valid = 1'b0;
        tick();
        k_we = 1'b0; in_valid = 1'b1; in_data = fill(255);
        tick();
        drain(ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL sat_drain_timeout: busy %b expected 0", busy); end
        vectors++;
        if (got_q.size() != 1) begin miscompares++; $display("FAIL sat_count: got %0d expected 1", got_q.size()); end
        else if (got_q[0] != SAT_EXP || got_q[0] != exp_q[0]) begin
            miscompares++; $display("FAIL sat_value: got %0d expected %0d", got_q[0], SAT_EXP);
        end
        $display("test_saturation done");
    endtask

    task automatic test_reset_midflight();
        int seen;
        clear_sb(); seen = 0; out_ready = 1'b1;
        k_we = 1'b1; k_data = rand_vec(); in_valid = 1'b0;
        tick();
        k_we = 1'b0; in_valid = 1'b1; in_data = rand_vec();
        tick();
        in_data = rand_vec();
        tick();
        in_valid = 1'b0;
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL mid_busy_before: got %b expected 1", busy); end
        rst = 1'b1;
        #1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_out_valid: got %b expected 0", out_valid); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_busy: got %b expected 0", busy); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL mid_in_ready: got %b expected 1", in_ready); end
        @(posedge clk);
        #1;
        rst = 1'b0; kmodel = '0; clear_sb();
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid === 1'b1) seen++;
        end
        vectors++; if (seen != 0 || got_q.size() != 0) begin miscompares++; $display("FAIL mid_ghost: got %0d valid cycles expected 0", seen); end
        $display("test_reset_midflight done");
    endtask

    task automatic test_random();
        bit           ok;
        bit           pv;
        bit           pr;
        logic [N-1:0] pd;
        int           outstanding;
        clear_sb();
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            k_we      = ($urandom_range(0, 15) == 0);
            k_data    = rand_vec();
            in_data   = rand_vec();
            pv = (out_valid === 1'b1); pr = out_ready; pd = out_data;
            #1;
            outstanding = exp_q.size() - got_q.size();
            vectors++; if (in_ready !== ((outstanding < 3) || out_ready)) begin miscompares++; $display("FAIL rnd_in_ready[%0d]: got %b expected %b", i, in_ready, (outstanding < 3) || out_ready); end
            vectors++; if (busy !== (outstanding > 0)) begin miscompares++; $display("FAIL rnd_busy[%0d]: got %b expected %b", i, busy, outstanding > 0); end
            tick();
            if (pv && !pr) begin
                vectors++; if (out_valid !== 1'b1 || out_data !== pd) begin miscompares++; $display("FAIL rnd_hold[%0d]: got %b/%0d expected 1/%0d", i, out_valid, out_data, pd); end
            end
        end
        drain(ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL rnd_drain_timeout: busy %b expected 0", busy); end
        vectors++; if (got_q.size() != exp_q.size()) begin miscompares++; $display("FAIL rnd_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            vectors++; if (got_q[i] != exp_q[i]) begin miscompares++; $display("FAIL rnd_data[%0d]: got %0d expected %0d", i, got_q[i], exp_q[i]); end
        end
        $display("test_random done: %0d results", got_q.size());
    endtask

    initial begin
        rst = 1'b1; k_we = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        k_data = '0; in_data = '0; kmodel = '0;
        test_reset();
        test_basic_mac();
        test_streaming();
        test_backpressure();
        test_kernel_swap();
        test_saturation();
        test_reset_midflight();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
